// File: rtl/hyperbus_pkg.sv
// Shared types and constants for the HyperBus RWDS latency logic.
package hyperbus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CA      = 3'd1,
        ST_LATENCY = 3'd2,
        ST_DATA_RD = 3'd3,
        ST_DATA_WR = 3'd4
    } hyperbus_rwds_lat_state_e;

    localparam int CaRwBit            = 47;
    localparam int CaAsBit            = 46;
    localparam int NumCaCyclesDefault = 3;

endpackage

// File: rtl/hyperbus_lat_counter.sv
// Loadable down-counter that saturates at zero and flags a count of one.
module hyperbus_lat_counter #(
    parameter int Width = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [Width-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_one
);

    logic [Width-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_one = (r_cnt == Width'(1));

endmodule

// File: rtl/hyperbus_rwds_latency_driver.sv
// Responder-side RWDS latency driver: CA capture, 1x/2x latency indication, data-phase enables.
// Optional macro HYPERBUS_REG_ZERO_LAT_EN: register-space writes bypass the initial latency.
module hyperbus_rwds_latency_driver
    import hyperbus_pkg::*;
#(
    parameter int NumCaCycles = NumCaCyclesDefault,
    parameter int LatCntWidth = 5
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     hyper_cs_ni,
    input  logic [15:0]              ca_word_i,
    input  logic [3:0]               cfg_latency_i,
    input  logic                     cfg_fixed_latency_i,
    input  logic                     refresh_collision_i,
    output logic                     rwds_o,
    output logic                     rwds_oe_o,
    output logic [16*NumCaCycles-1:0] ca_o,
    output logic                     ca_valid_o,
    output logic                     data_rd_en_o,
    output logic                     data_wr_en_o,
    output logic                     busy_o
);

    localparam int CaW    = 16 * NumCaCycles;
    localparam int CaCntW = $clog2(NumCaCycles + 1);

    hyperbus_rwds_lat_state_e r_state, w_state_next;

    logic [CaW-1:0]         r_ca;
    logic [CaCntW-1:0]      r_ca_cnt;
    logic                   r_lat2x;
    logic                   r_ca_valid;
    logic                   w_lat2x_now;
    logic                   w_ca_last;
    logic                   w_lat_one;
    logic [LatCntWidth-1:0] w_lat_base;
    logic [LatCntWidth-1:0] w_lat_load;

    assign w_lat2x_now = cfg_fixed_latency_i | refresh_collision_i;
    assign w_ca_last   = (r_state == ST_CA) && (r_ca_cnt == CaCntW'(NumCaCycles - 1));
    assign w_lat_base  = (cfg_latency_i == 4'd0) ? LatCntWidth'(1) : LatCntWidth'(cfg_latency_i);

`ifdef HYPERBUS_REG_ZERO_LAT_EN
    // Register writes get a single-cycle count so DATA_WR follows ca_valid directly.
    assign w_lat_load = (!r_ca[CaRwBit] && r_ca[CaAsBit]) ? LatCntWidth'(1)
                                                          : (w_lat_base << r_lat2x);
`else
    assign w_lat_load = w_lat_base << r_lat2x;
`endif

    hyperbus_lat_counter #(
        .Width (LatCntWidth)
    ) u_lat_counter (
        .i_clk      (clk_i),
        .i_rst      (rst_i),
        .i_clr      (hyper_cs_ni),
        .i_load     (w_ca_last && !hyper_cs_ni),
        .i_load_val (w_lat_load),
        .i_dec      (r_state == ST_LATENCY),
        .o_one      (w_lat_one)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!hyper_cs_ni) w_state_next = ST_CA;
            end
            ST_CA: begin
                if (hyper_cs_ni)    w_state_next = ST_IDLE;
                else if (w_ca_last) w_state_next = ST_LATENCY;
            end
            ST_LATENCY: begin
                if (hyper_cs_ni)    w_state_next = ST_IDLE;
                else if (w_lat_one) w_state_next = r_ca[CaRwBit] ? ST_DATA_RD : ST_DATA_WR;
            end
            ST_DATA_RD, ST_DATA_WR: begin
                if (hyper_cs_ni) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_ca       <= '0;
            r_ca_cnt   <= '0;
            r_lat2x    <= 1'b0;
            r_ca_valid <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ca_valid <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (!hyper_cs_ni) begin
                    r_ca[CaW-1 -: 16] <= ca_word_i;
                    r_lat2x           <= w_lat2x_now;
                    r_ca_cnt          <= CaCntW'(1);
                end
            end else if (hyper_cs_ni) begin
                r_ca_cnt <= '0;
            end else if (r_state == ST_CA) begin
                // r_ca_cnt is the index of the word arriving this cycle, MSW first
                for (int k = 1; k < NumCaCycles; k++) begin
                    if (r_ca_cnt == CaCntW'(k)) r_ca[16*(NumCaCycles-1-k) +: 16] <= ca_word_i;
                end
                if (w_ca_last) begin
                    r_ca_valid <= 1'b1;
                    r_ca_cnt   <= '0;
                end else begin
                    r_ca_cnt <= r_ca_cnt + 1'b1;
                end
            end
        end
    end

    // The first CA word arrives while still in IDLE, so RWDS is driven then too.
    assign rwds_oe_o = !rst_i && !hyper_cs_ni &&
                       ((r_state == ST_IDLE) || (r_state == ST_CA) || (r_state == ST_DATA_RD));
    assign rwds_o    = rwds_oe_o && (((r_state == ST_IDLE) && w_lat2x_now) ||
                                     ((r_state == ST_CA) && r_lat2x));

    assign ca_o         = r_ca;
    assign ca_valid_o   = r_ca_valid;
    assign data_rd_en_o = (r_state == ST_DATA_RD);
    assign data_wr_en_o = (r_state == ST_DATA_WR);
    assign busy_o       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_hyperbus_rwds_latency_driver.sv
// Self-checking bench for hyperbus_rwds_latency_driver using an expected-transaction queue.
module tb_hyperbus_rwds_latency_driver;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        hyper_cs_ni = 1'b1;
    logic [15:0] ca_word_i = '0;
    logic [3:0]  cfg_latency_i = '0;
    logic        cfg_fixed_latency_i = 1'b0;
    logic        refresh_collision_i = 1'b0;
    logic        rwds_o, rwds_oe_o, ca_valid_o, data_rd_en_o, data_wr_en_o, busy_o;
    logic [47:0] ca_o;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [47:0] ca;
        logic        rwds;
        int          lat;
        logic        rd;
    } exp_t;
    exp_t sb_q[$];

    logic [2:0]  obs_oe, obs_rwds;
    logic        obs_valid, obs_valid_next, obs_lat_oe, obs_rd, obs_wr, obs_data_oe, obs_data_rwds;
    logic        obs_rise_oe, obs_busy_after, obs_en_after;
    logic [47:0] obs_ca;
    int          obs_lat;

    hyperbus_rwds_latency_driver dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .hyper_cs_ni         (hyper_cs_ni),
        .ca_word_i           (ca_word_i),
        .cfg_latency_i       (cfg_latency_i),
        .cfg_fixed_latency_i (cfg_fixed_latency_i),
        .refresh_collision_i (refresh_collision_i),
        .rwds_o              (rwds_o),
        .rwds_oe_o           (rwds_oe_o),
        .ca_o                (ca_o),
        .ca_valid_o          (ca_valid_o),
        .data_rd_en_o        (data_rd_en_o),
        .data_wr_en_o        (data_wr_en_o),
        .busy_o              (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t make_exp(input logic [47:0] ca, input logic [3:0] lat,
                                      input logic fixed, input logic refresh);
        exp_t e;
        e.ca   = ca;
        e.rwds = fixed | refresh;
        e.rd   = ca[47];
        e.lat  = ((lat == 4'd0) ? 1 : int'(lat)) * ((fixed | refresh) ? 2 : 1);
`ifdef HYPERBUS_REG_ZERO_LAT_EN
        if (!ca[47] && ca[46]) e.lat = 1;
`endif
        return e;
    endfunction

    // Drives one complete transaction and records what the DUT did; no comparisons here.
    task automatic drive_txn(input logic [47:0] ca, input logic [3:0] lat,
                             input logic fixed, input logic refresh);
        @(posedge clk_i); #1;
        hyper_cs_ni = 1'b0; cfg_latency_i = lat;
        cfg_fixed_latency_i = fixed; refresh_collision_i = refresh;
        ca_word_i = ca[47:32];
        @(negedge clk_i); obs_oe[0] = rwds_oe_o; obs_rwds[0] = rwds_o;
        @(posedge clk_i); #1;
        refresh_collision_i = 1'b0; ca_word_i = ca[31:16];
        @(negedge clk_i); obs_oe[1] = rwds_oe_o; obs_rwds[1] = rwds_o;
        @(posedge clk_i); #1;
        ca_word_i = ca[15:0];
        @(negedge clk_i); obs_oe[2] = rwds_oe_o; obs_rwds[2] = rwds_o;
        @(posedge clk_i); #1;
        // Perturb configuration mid-transaction; it must have no effect.
        cfg_latency_i = ~lat; cfg_fixed_latency_i = ~fixed; refresh_collision_i = 1'b1;
        ca_word_i = 16'(($urandom));
        @(negedge clk_i);
        obs_valid = ca_valid_o; obs_ca = ca_o; obs_lat_oe = rwds_oe_o;
        obs_lat = -1; obs_valid_next = 1'bx; obs_rd = 1'b0; obs_wr = 1'b0;
        obs_data_oe = 1'bx; obs_data_rwds = 1'bx;
        for (int n = 1; n <= 64; n++) begin
            @(posedge clk_i); #1;
            @(negedge clk_i);
            if (n == 1) obs_valid_next = ca_valid_o;
            if (data_rd_en_o || data_wr_en_o) begin
                obs_lat = n; obs_rd = data_rd_en_o; obs_wr = data_wr_en_o;
                obs_data_oe = rwds_oe_o; obs_data_rwds = rwds_o;
                break;
            end
        end
        repeat (2) @(posedge clk_i);
        #1;
        hyper_cs_ni = 1'b1; refresh_collision_i = 1'b0;
        @(negedge clk_i); obs_rise_oe = rwds_oe_o;
        @(posedge clk_i); #1;
        @(negedge clk_i); obs_busy_after = busy_o; obs_en_after = data_rd_en_o | data_wr_en_o;
    endtask

    task automatic test_reset;
        @(negedge clk_i);
        n_tests++;
        if ({rwds_o, rwds_oe_o, ca_valid_o, data_rd_en_o, data_wr_en_o, busy_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 000000",
                     {rwds_o, rwds_oe_o, ca_valid_o, data_rd_en_o, data_wr_en_o, busy_o});
        end
        n_tests++;
        if (ca_o !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_ca: got %h required 0", ca_o);
        end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        $display("[TB] reset released");
    endtask

    task automatic test_transactions;
        logic [47:0] t_ca[5]    = '{48'h8000_0000_0010, 48'h0000_1234_5678, 48'h8000_00AB_0000,
                                    48'h4000_0000_0001, 48'h8123_4567_89AB};
        logic [3:0]  t_lat[5]   = '{4'd6, 4'd6, 4'd0, 4'd6, 4'd15};
        logic        t_fixed[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic        t_refr[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            sb_q.push_back(make_exp(t_ca[i], t_lat[i], t_fixed[i], t_refr[i]));
            drive_txn(t_ca[i], t_lat[i], t_fixed[i], t_refr[i]);
            e = sb_q.pop_front();
            $display("[TB] txn %0d ca=%h L=%0d fixed=%0b refresh=%0b lat_seen=%0d",
                     i, t_ca[i], t_lat[i], t_fixed[i], t_refr[i], obs_lat);
            for (int c = 0; c < 3; c++) begin
                n_tests++;
                if ({obs_oe[c], obs_rwds[c]} !== {1'b1, e.rwds}) begin
                    n_fail++;
                    $display("FAIL txn%0d_ca_rwds cycle %0d: oe/rwds got %b%b required 1%b",
                             i, c, obs_oe[c], obs_rwds[c], e.rwds);
                end
            end
            n_tests++;
            if ({obs_valid, obs_valid_next, obs_lat_oe} !== 3'b100) begin
                n_fail++;
                $display("FAIL txn%0d_ca_valid: valid/next/oe got %b%b%b required 100",
                         i, obs_valid, obs_valid_next, obs_lat_oe);
            end
            n_tests++;
            if (obs_ca !== e.ca) begin
                n_fail++;
                $display("FAIL txn%0d_ca: got %h required %h", i, obs_ca, e.ca);
            end
            n_tests++;
            if (obs_lat !== e.lat) begin
                n_fail++;
                $display("FAIL txn%0d_latency: got %0d required %0d", i, obs_lat, e.lat);
            end
            n_tests++;
            if ({obs_rd, obs_wr, obs_data_oe, obs_data_rwds} !== {e.rd, ~e.rd, e.rd, 1'b0}) begin
                n_fail++;
                $display("FAIL txn%0d_data_phase: rd/wr/oe/rwds got %b%b%b%b required %b%b%b0",
                         i, obs_rd, obs_wr, obs_data_oe, obs_data_rwds, e.rd, ~e.rd, e.rd);
            end
            n_tests++;
            if ({obs_rise_oe, obs_busy_after, obs_en_after} !== 3'b000) begin
                n_fail++;
                $display("FAIL txn%0d_cs_rise: oe/busy/en got %b%b%b required 000",
                         i, obs_rise_oe, obs_busy_after, obs_en_after);
            end
        end
    endtask

    task automatic test_abort;
        logic seen_valid = 1'b0;
        logic oe_c2, oe_c3, busy_c3, busy_after;
        @(posedge clk_i); #1;
        hyper_cs_ni = 1'b0; cfg_latency_i = 4'd4; ca_word_i = 16'h8000;
        @(posedge clk_i); #1;
        ca_word_i = 16'h0000;
        @(negedge clk_i); oe_c2 = rwds_oe_o;
        @(posedge clk_i); #1;
        hyper_cs_ni = 1'b1; ca_word_i = 16'h0055;
        @(negedge clk_i); oe_c3 = rwds_oe_o; busy_c3 = busy_o;
        @(posedge clk_i); #1;
        @(negedge clk_i); busy_after = busy_o; seen_valid = ca_valid_o;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk_i);
            seen_valid = seen_valid | ca_valid_o;
        end
        $display("[TB] abort txn: oe_before=%0b oe_at_rise=%0b busy_after=%0b valid_seen=%0b",
                 oe_c2, oe_c3, busy_after, seen_valid);
        n_tests++;
        if ({oe_c2, oe_c3, busy_c3} !== 3'b101) begin
            n_fail++;
            $display("FAIL abort_oe_gate: oe2/oe3/busy3 got %b%b%b required 101", oe_c2, oe_c3, busy_c3);
        end
        n_tests++;
        if ({busy_after, seen_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_no_valid: busy/valid got %b%b required 00", busy_after, seen_valid);
        end
    endtask

    task automatic test_reset_mid_latency;
        exp_t e;
        @(posedge clk_i); #1;
        hyper_cs_ni = 1'b0; cfg_latency_i = 4'd8; cfg_fixed_latency_i = 1'b0;
        ca_word_i = 16'hC0DE;
        @(posedge clk_i); #1; ca_word_i = 16'hBEEF;
        @(posedge clk_i); #1; ca_word_i = 16'h1234;
        repeat (3) @(posedge clk_i);
        #3;
        rst_i = 1'b1; hyper_cs_ni = 1'b1;
        #1;
        $display("[TB] reset pulsed mid-latency");
        n_tests++;
        if ({rwds_o, rwds_oe_o, ca_valid_o, data_rd_en_o, data_wr_en_o, busy_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %b required 000000",
                     {rwds_o, rwds_oe_o, ca_valid_o, data_rd_en_o, data_wr_en_o, busy_o});
        end
        n_tests++;
        if (ca_o !== 48'h0) begin
            n_fail++;
            $display("FAIL midrst_ca: got %h required 0", ca_o);
        end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        sb_q.push_back(make_exp(48'h8000_1111_2222, 4'd3, 1'b0, 1'b0));
        drive_txn(48'h8000_1111_2222, 4'd3, 1'b0, 1'b0);
        e = sb_q.pop_front();
        $display("[TB] post-reset txn ca=%h lat_seen=%0d", obs_ca, obs_lat);
        n_tests++;
        if ({obs_valid, obs_ca} !== {1'b1, e.ca}) begin
            n_fail++;
            $display("FAIL midrst_recapture: valid/ca got %b/%h required 1/%h", obs_valid, obs_ca, e.ca);
        end
        n_tests++;
        if ({obs_lat, obs_rd} !== {e.lat, e.rd}) begin
            n_fail++;
            $display("FAIL midrst_latency: lat/rd got %0d/%b required %0d/%b", obs_lat, obs_rd, e.lat, e.rd);
        end
    endtask

    initial begin
        test_reset();
        test_transactions();
        test_abort();
        test_reset_mid_latency();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hyperbus_rwds_latency_driver.md
Name: hyperbus_rwds_latency_driver

Overview:
- Responder-side counterpart of the controller's RWDS latency sampler; used in the HyperRAM device model and the loopback/self-test responder.
- Tracks a transaction from CS# fall and captures the 3-cycle command/address (CA) phase.
- During CA, drives RWDS to announce 1x or 2x initial latency, times that latency, then enables the read or write data phase until CS# rises.
- Clocked at the hyper_ck rate: one clk_i cycle equals one CK period; inputs are already synchronous to clk_i.

Parameters:
- NumCaCycles, 3, number of CK cycles (16-bit words) in the CA phase.
- LatCntWidth, 5, width of the latency counter; must hold 2*15.

Ports:
- clk_i  in  1  responder clock, one cycle per CK period.
- rst_i  in  1  asynchronous reset, active-high.
- hyper_cs_ni  in  1  chip select, active-low, synchronous.
- ca_word_i  in  16  CA word from the DDR input stage, one per cycle.
- cfg_latency_i  in  4  initial latency in CK cycles; 0 is treated as 1.
- cfg_fixed_latency_i  in  1  1 = always request 2x latency.
- refresh_collision_i  in  1  device-side request for 2x latency on this transaction.
- rwds_o  out  1  RWDS drive value.
- rwds_oe_o  out  1  RWDS output enable.
- ca_o  out  48  captured CA.
- ca_valid_o  out  1  one-cycle strobe when ca_o is complete.
- data_rd_en_o  out  1  read data phase active (RWDS toggling enabled).
- data_wr_en_o  out  1  write data phase active (RWDS is input/mask).
- busy_o  out  1  state is not IDLE.

Behaviour:
- Reset: all outputs 0; ca_o 0; state IDLE; counters 0.
- States: IDLE, CA, LATENCY, DATA_RD, DATA_WR.
- IDLE -> CA when hyper_cs_ni is low.
  - In the same edge, latch lat2x = cfg_fixed_latency_i | refresh_collision_i.
  - Capture the first CA word into ca_o[47:32].
  - ca_cnt = 1.
- CA:
  - Shift in subsequent words: ca_o[31:16], then ca_o[15:0].
  - rwds_oe_o = 1 and rwds_o = lat2x from the first CA cycle through cycle NumCaCycles.
  - After word NumCaCycles, pulse ca_valid_o for one cycle.
  - Load lat_cnt = max(cfg_latency_i, 1) << lat2x.
  - Transition to LATENCY.
- LATENCY:
  - rwds_oe_o = 0; lat_cnt decrements each cycle.
  - On lat_cnt == 1, go to DATA_RD if ca_o[47] == 1, else DATA_WR.
  - LATENCY lasts exactly lat_cnt cycles; ca_valid_o to first data_*_en_o = (max(L,1) << lat2x) cycles.
- DATA_RD:
  - data_rd_en_o = 1, rwds_oe_o = 1, rwds_o = 0; the DDR stage toggles RWDS.
  - Remain until CS# rises.
- DATA_WR:
  - data_wr_en_o = 1, rwds_oe_o = 0.
  - Remain until CS# rises.
- CS# rise in any state:
  - rwds_oe_o is gated combinationally with ~hyper_cs_ni, so there is no contention in that cycle.
  - Next edge: go to IDLE; clear data enables and counters. ca_o holds its value.
  - CS# rising during CA aborts the phase: no ca_valid_o.
- cfg_* inputs are sampled only at their load points (CS# fall, end of CA). Changes mid-transaction have no effect.
- Reset asserted mid-transaction: immediate asynchronous return to reset values.

Optional Feature:
- Macro: HYPERBUS_REG_ZERO_LAT_EN.
- Defined: a register-space write (ca_o[47] == 0 && ca_o[46] == 1) skips LATENCY and enters DATA_WR in the cycle after ca_valid_o. RWDS latency indication is still driven during CA.
- Undefined: every transaction passes through LATENCY.

Decomposition:
- hyperbus_pkg holds:
  - the state enum `hyperbus_rwds_lat_state_e`;
  - constants for the CA bit positions (`CaRwBit = 47`, `CaAsBit = 46`);
  - the NumCaCycles default.
- One sub-module, `hyperbus_lat_counter`: loadable down-counter with a one-flag output, reused by the controller PHY.

Test Plan:
- Read, L=6, fixed=0, refresh=0, CA=0x8000_0000_0010:
  - rwds_o = 0 with oe = 1 for 3 cycles;
  - ca_valid_o, then 6 cycles later data_rd_en_o = 1.
- Write, L=6, refresh_collision_i = 1 at CS# fall:
  - rwds_o = 1 during CA;
  - data_wr_en_o asserts 12 cycles after ca_valid_o.
- cfg_latency_i = 0, fixed = 1 → latency of 2 cycles (clamped 1, doubled).
- CS# deasserted after 2 CA cycles:
  - no ca_valid_o;
  - rwds_oe_o drops combinationally in the same cycle;
  - busy_o = 0 next cycle.
- Register write CA = 0x4000_0000_0001:
  - with HYPERBUS_REG_ZERO_LAT_EN, data_wr_en_o asserts the cycle after ca_valid_o;
  - without it, after L cycles.
- rst_i pulsed mid-LATENCY → all outputs 0 asynchronously; next CS# fall starts a clean CA capture.
